mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares the single-port unified memory between the CPU's instruction fetch path and its load/store (LDUR/STUR/LDURB/STURB) path. It runs one transaction at a time: it latches the winning request, drives the memory port until the memory acknowledges, and returns a one-cycle acknowledge with read data to the requester. It sits between fetch/memory stages and the memory model. The pipeline uses the requester-side handshake to stall.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store; one transaction at a time.
// Optional fetch-fairness counter enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter
`ifdef ARB_FAIRNESS_EN
#(
    parameter int MAX_DATA_RUN = 4
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    input  logic [3:0]  dm_xfer,
    output logic        dm_ack,
    output logic [63:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_xfer,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_t;

    localparam logic [3:0] XFER_WORD  = 4'b0100;
    localparam logic [3:0] XFER_RESET = 4'b1000;

    state_t      state_q, state_d;
    logic        owner_dm_q, owner_dm_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_xfer_q, mem_xfer_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] dm_rdata_q, dm_rdata_d;

    logic        pick_if;
    logic        grant_if;
    logic        grant_dm;

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    // Consecutive data grants won while fetch was also waiting.
    logic [3:0] run_q, run_d;

    assign pick_if = if_req && (!dm_req || (run_q == MAX_RUN));

    always_comb begin
        run_d = run_q;
        if (grant_if) begin
            run_d = 4'd0;
        end else if (grant_dm) begin
            run_d = if_req ? run_q + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 4'd0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign pick_if = if_req && !dm_req;
`endif

    assign grant_if = (state_q == IDLE) && pick_if;
    assign grant_dm = (state_q == IDLE) && dm_req && !pick_if;

    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_xfer_d  = mem_xfer_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = BUSY_IF;
                    owner_dm_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_xfer_d  = XFER_WORD;
                end else if (grant_dm) begin
                    state_d     = BUSY_DM;
                    owner_dm_d  = 1'b1;
                    mem_write_d = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_xfer_d  = dm_xfer;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata[31:0];
                    state_d    = RESP;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    if (!mem_write_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_xfer_q  <= XFER_RESET;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_xfer_q  <= mem_xfer_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign busy      = (state_q != IDLE);
    assign if_ack    = (state_q == RESP) && !owner_dm_q;
    assign dm_ack    = (state_q == RESP) && owner_dm_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_xfer  = mem_xfer_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_write;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [3:0]  dm_xfer;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        mem_req;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_xfer;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] exp_if_rdata;
    logic [63:0] exp_dm_rdata;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_xfer   (dm_xfer),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_xfer  (mem_xfer),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_write = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_xfer = 4'b0000;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        vectors++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b mem_req=%b mem_write=%b want 0 0 0", busy, mem_req, mem_write);
        end
        vectors++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin
            errors++; $display("FAIL reset_acks: if_ack=%b dm_ack=%b want 0 0", if_ack, dm_ack);
        end
        vectors++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_xfer !== 4'b1000) begin
            errors++; $display("FAIL reset_mem: addr=%h wdata=%h xfer=%b want 0 0 1000", mem_addr, mem_wdata, mem_xfer);
        end
        vectors++; if (if_rdata !== 32'd0 || dm_rdata !== 64'd0) begin
            errors++; $display("FAIL reset_rdata: if=%h dm=%h want 0 0", if_rdata, dm_rdata);
        end
        reset = 1'b0;
        tick();
        exp_if_rdata = 32'd0;
        exp_dm_rdata = 64'd0;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 64'h40;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 64'h40 || mem_xfer !== 4'b0100 || mem_write !== 1'b0) begin
            errors++; $display("FAIL fetch_c1: req=%b addr=%h xfer=%b wr=%b want 1 40 0100 0", mem_req, mem_addr, mem_xfer, mem_write);
        end
        mem_ack = 1'b1; mem_rdata = 64'h00000000_91000421;
        tick();
        mem_ack = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        exp_if_rdata = 32'h91000421;
        vectors++; if (if_ack !== 1'b1 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL fetch_c2_ack: if_ack=%b dm_ack=%b mem_req=%b want 1 0 0", if_ack, dm_ack, mem_req);
        end
        vectors++; if (if_rdata !== exp_if_rdata) begin
            errors++; $display("FAIL fetch_c2_rdata: got %h want %h", if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0 || if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_c3: busy=%b if_ack=%b want 0 0", busy, if_ack);
        end
    endtask

    task automatic test_load();
        dm_req = 1'b1; dm_write = 1'b0; dm_addr = 64'h20; dm_xfer = 4'b1000;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 64'h20 || mem_xfer !== 4'b1000) begin
            errors++; $display("FAIL load_c1: req=%b wr=%b addr=%h xfer=%b", mem_req, mem_write, mem_addr, mem_xfer);
        end
        mem_ack = 1'b1; mem_rdata = 64'h01234567_89ABCDEF;
        tick();
        mem_ack = 1'b0;
        exp_dm_rdata = 64'h01234567_89ABCDEF;
        vectors++; if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_rdata !== exp_dm_rdata) begin
            errors++; $display("FAIL load_resp: dm_ack=%b if_ack=%b rdata=%h want 1 0 %h", dm_ack, if_ack, dm_rdata, exp_dm_rdata);
        end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_store_latency();
        dm_req = 1'b1; dm_write = 1'b1; dm_addr = 64'h10; dm_wdata = 64'hAA; dm_xfer = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++; if (mem_req !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 64'h10 ||
                           mem_wdata !== 64'hAA || mem_xfer !== 4'b0001 || dm_ack !== 1'b0) begin
                errors++; $display("FAIL store_hold_c%0d: req=%b wr=%b addr=%h wdata=%h xfer=%b ack=%b", c,
                                   mem_req, mem_write, mem_addr, mem_wdata, mem_xfer, dm_ack);
            end
            // Requester changes after grant must not reach the memory port.
            dm_wdata = 64'h55; dm_addr = 64'h99; dm_xfer = 4'b1000;
            if (c == 3) begin
                mem_ack = 1'b1; mem_rdata = 64'h1234;
            end
        end
        tick();
        mem_ack = 1'b0;
        vectors++; if (dm_ack !== 1'b1 || dm_rdata !== exp_dm_rdata) begin
            errors++; $display("FAIL store_resp: dm_ack=%b rdata=%h want 1 %h", dm_ack, dm_rdata, exp_dm_rdata);
        end
        tick();
        vectors++; if (dm_ack !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL store_after: dm_ack=%b busy=%b mem_req=%b want 0 0 0", dm_ack, busy, mem_req);
        end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        int if_acks = 0;
        int dm_acks = 0;
        if_req = 1'b1; if_addr = 64'h80;
        dm_req = 1'b1; dm_write = 1'b0; dm_addr = 64'h300; dm_xfer = 4'b1000;
        tick();
        vectors++; if (mem_addr !== 64'h300 || mem_xfer !== 4'b1000) begin
            errors++; $display("FAIL simul_first_grant: addr=%h xfer=%b want 300 1000", mem_addr, mem_xfer);
        end
        mem_ack = 1'b1; mem_rdata = 64'h11112222_33334444;
        tick();
        mem_ack = 1'b0;
        exp_dm_rdata = 64'h11112222_33334444;
        if_acks += int'(if_ack); dm_acks += int'(dm_ack);
        dm_req = 1'b0;
        tick();
        if_acks += int'(if_ack); dm_acks += int'(dm_ack);
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 64'h80 || mem_xfer !== 4'b0100) begin
            errors++; $display("FAIL simul_second_grant: req=%b addr=%h xfer=%b want 1 80 0100", mem_req, mem_addr, mem_xfer);
        end
        mem_ack = 1'b1; mem_rdata = 64'hCAFE0000_D503201F;
        tick();
        mem_ack = 1'b0;
        exp_if_rdata = 32'hD503201F;
        if_acks += int'(if_ack); dm_acks += int'(dm_ack);
        if_req = 1'b0;
        tick();
        if_acks += int'(if_ack); dm_acks += int'(dm_ack);
        vectors++; if (if_acks != 1 || dm_acks != 1) begin
            errors++; $display("FAIL simul_ack_count: if=%0d dm=%0d want 1 1", if_acks, dm_acks);
        end
        vectors++; if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            errors++; $display("FAIL simul_rdata: if=%h dm=%h want %h %h", if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
        end
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        vectors++; if (if_ack !== 1'b0 || dm_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL spurious_ack: if_ack=%b dm_ack=%b busy=%b want 0 0 0", if_ack, dm_ack, busy);
        end
        tick();
        mem_ack = 1'b0;
        vectors++; if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            errors++; $display("FAIL spurious_rdata: if=%h dm=%h want %h %h", if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        dm_req = 1'b1; dm_write = 1'b1; dm_addr = 64'h500; dm_wdata = 64'h77; dm_xfer = 4'b1000;
        tick();
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 64'h500) begin
            errors++; $display("FAIL midrst_busy: req=%b addr=%h want 1 500", mem_req, mem_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; dm_req = 1'b0;
        vectors++; if (mem_req !== 1'b0 || busy !== 1'b0 || dm_ack !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: req=%b busy=%b dm_ack=%b wr=%b want 0 0 0 0", mem_req, busy, dm_ack, mem_write);
        end
        vectors++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_xfer !== 4'b1000 ||
                       if_rdata !== 32'd0 || dm_rdata !== 64'd0) begin
            errors++; $display("FAIL midrst_regs: addr=%h wdata=%h xfer=%b if=%h dm=%h", mem_addr, mem_wdata, mem_xfer, if_rdata, dm_rdata);
        end
        tick();
        vectors++; if (dm_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_no_ack: dm_ack=%b busy=%b want 0 0", dm_ack, busy);
        end
    endtask

    task automatic test_fairness();
        logic [5:0] exp_fetch;
        logic       got_fetch;
        int         n;
`ifdef ARB_FAIRNESS_EN
        exp_fetch = 6'b010000;
`else
        exp_fetch = 6'b000000;
`endif
        if_req = 1'b1; if_addr = 64'h100;
        dm_req = 1'b1; dm_write = 1'b0; dm_addr = 64'h200; dm_xfer = 4'b1000;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!mem_req && n < 10);
            if (!mem_req) begin
                vectors++; errors++;
                $display("FAIL fair_timeout_g%0d: mem_req=%b want 1", g, mem_req);
                break;
            end
            got_fetch = (mem_addr == 64'h100);
            vectors++; if (got_fetch !== exp_fetch[g]) begin
                errors++; $display("FAIL fair_grant_g%0d: fetch=%b want %b", g, got_fetch, exp_fetch[g]);
            end
            mem_ack = 1'b1; mem_rdata = 64'(g);
            tick();
            mem_ack = 1'b0;
            vectors++; if (if_ack !== got_fetch || dm_ack !== !got_fetch) begin
                errors++; $display("FAIL fair_ack_g%0d: if_ack=%b dm_ack=%b fetch=%b", g, if_ack, dm_ack, got_fetch);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        tick();
        vectors++; if (busy !== 1'b0) begin
            errors++; $display("FAIL fair_idle: busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_load();
        test_store_latency();
        test_simultaneous();
        test_spurious_ack();
        test_reset_mid_op();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
